// File: rtl/fifo_pkg.sv
// Constants and helpers shared by the synchronous and dual-clock FIFO variants.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Bit positions inside the error-flag vector.
  localparam int ERR_OVF   = 0;
  localparam int ERR_UDF   = 1;
  localparam int ERR_WIDTH = 2;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Dual-port storage array: synchronous write, asynchronous read, no reset.
module fifo_mem_dp #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with exact fill count, programmable thresholds,
// sticky error flags and selectable first-word-fall-through read mode.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int MEMORY_WIDTH    = 8,
  parameter int ADDRESS_SIZE    = 4,
  parameter int ALMOST_FULL_TH  = 14,
  parameter int ALMOST_EMPTY_TH = 2,
  parameter int FWFT            = FWFT_OFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_en,
  input  logic [MEMORY_WIDTH-1:0] wdata,
  input  logic                    r_en,
  input  logic                    err_clr,
  output logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    w_full,
  output logic                    r_empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int DEPTH = 1 << ADDRESS_SIZE;
  localparam int CNT_W = ADDRESS_SIZE + 1;

  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af
    $error("fifo_sync_param: ALMOST_FULL_TH out of range 1..DEPTH");
  end
  if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_param: ALMOST_EMPTY_TH out of range 0..DEPTH-1");
  end

  logic [CNT_W-1:0]     w_ptr_q, w_ptr_d;
  logic [CNT_W-1:0]     r_ptr_q, r_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic                 wr_acc, rd_acc;
  logic [MEMORY_WIDTH-1:0] mem_rdata;

  assign w_full       = (count_q == CNT_W'(DEPTH));
  assign r_empty      = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(ALMOST_FULL_TH));
  assign almost_empty = (count_q <= CNT_W'(ALMOST_EMPTY_TH));
  assign count        = count_q;
  assign overflow     = err_q[ERR_OVF];
  assign underflow    = err_q[ERR_UDF];

  // Acceptance looks only at this cycle's count, so a simultaneous
  // read never makes room for a write at full (and vice versa at empty).
  assign wr_acc = w_en & ~w_full;
  assign rd_acc = r_en & ~r_empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    err_d   = err_q;
    if (wr_acc) w_ptr_d = w_ptr_q + CNT_W'(1);
    if (rd_acc) r_ptr_d = r_ptr_q + CNT_W'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (err_clr) err_d = '0;
    if (w_en & w_full)  err_d[ERR_OVF] = 1'b1;
    if (r_en & r_empty) err_d[ERR_UDF] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  fifo_mem_dp #(
    .WIDTH  (MEMORY_WIDTH),
    .ADDR_W (ADDRESS_SIZE)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (w_ptr_q[ADDRESS_SIZE-1:0]),
    .wdata_i (wdata),
    .raddr_i (r_ptr_q[ADDRESS_SIZE-1:0]),
    .rdata_o (mem_rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    assign rdata = mem_rdata;
  end else begin : g_reg
    logic [MEMORY_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rdata_q <= '0;
      else if (rd_acc) rdata_q <= mem_rdata;
    end
    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives a registered-read and an FWFT instance with identical stimulus and
// checks both against a queue-based model of the FIFO.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int W     = 8;
  localparam int AS    = 4;
  localparam int DEPTH = 16;
  localparam int AF_TH = 14;
  localparam int AE_TH = 2;

  logic clk = 1'b0, rst_n = 1'b0, w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
  logic [W-1:0] wdata = '0;

  logic [W-1:0] rdata0, rdata1;
  logic full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic ovf0, ovf1, udf0, udf1;
  logic [AS:0] cnt0, cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] exp_rd0 = '0;
  bit m_ovf = 0, m_udf = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.MEMORY_WIDTH(W), .ADDRESS_SIZE(AS), .ALMOST_FULL_TH(AF_TH),
                    .ALMOST_EMPTY_TH(AE_TH), .FWFT(FWFT_OFF)) u_reg (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .wdata(wdata), .r_en(r_en),
    .err_clr(err_clr), .rdata(rdata0), .w_full(full0), .r_empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(udf0));

  fifo_sync_param #(.MEMORY_WIDTH(W), .ADDRESS_SIZE(AS), .ALMOST_FULL_TH(AF_TH),
                    .ALMOST_EMPTY_TH(AE_TH), .FWFT(FWFT_ON)) u_fwft (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .wdata(wdata), .r_en(r_en),
    .err_clr(err_clr), .rdata(rdata1), .w_full(full1), .r_empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(udf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int n;
    n = q.size();
    chk({ph, ":count0"}, 32'(cnt0), n);
    chk({ph, ":count1"}, 32'(cnt1), n);
    chk({ph, ":empty0"}, 32'(empty0), 32'(n == 0));
    chk({ph, ":empty1"}, 32'(empty1), 32'(n == 0));
    chk({ph, ":full0"}, 32'(full0), 32'(n == DEPTH));
    chk({ph, ":full1"}, 32'(full1), 32'(n == DEPTH));
    chk({ph, ":afull0"}, 32'(af0), 32'(n >= AF_TH));
    chk({ph, ":afull1"}, 32'(af1), 32'(n >= AF_TH));
    chk({ph, ":aempty0"}, 32'(ae0), 32'(n <= AE_TH));
    chk({ph, ":aempty1"}, 32'(ae1), 32'(n <= AE_TH));
    chk({ph, ":ovf0"}, 32'(ovf0), 32'(m_ovf));
    chk({ph, ":ovf1"}, 32'(ovf1), 32'(m_ovf));
    chk({ph, ":udf0"}, 32'(udf0), 32'(m_udf));
    chk({ph, ":udf1"}, 32'(udf1), 32'(m_udf));
    chk({ph, ":rdata_reg"}, 32'(rdata0), 32'(exp_rd0));
    if (n > 0) chk({ph, ":rdata_fwft"}, 32'(rdata1), 32'(q[0]));
  endtask

  // One clock cycle of stimulus; model follows the FIFO rules on the edge.
  task automatic step(input string ph, input bit w, input logic [W-1:0] d,
                      input bit r, input bit clr);
    bit full, empty;
    w_en = w; wdata = d; r_en = r; err_clr = clr;
    @(posedge clk);
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (clr) begin m_ovf = 0; m_udf = 0; end
    if (w && full)  m_ovf = 1;
    if (r && empty) m_udf = 1;
    if (r && !empty) exp_rd0 = q.pop_front();
    if (w && !full)  q.push_back(d);
    #1;
    w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
    check_all(ph);
  endtask

  initial begin
    #12;
    check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 16; i++) step("fill", 1'b1, W'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full0), 1);
    step("overflow_wr", 1'b1, W'($urandom), 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf0), 1);

    for (int i = 0; i < 16; i++) begin
      step("drain", 1'b0, '0, 1'b1, 1'b0);
      chk("drain_order", 32'(rdata0), i);
    end
    step("underflow_rd", 1'b0, '0, 1'b1, 1'b0);
    chk("udf_set", 32'(udf0), 1);

    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 5; i++) step("wrap_wr", 1'b1, W'($urandom), 1'b0, 1'b0);
      chk("wrap_cnt_le5", 32'(cnt0 <= 5), 1);
      for (int i = 0; i < 5; i++) step("wrap_rd", 1'b0, '0, 1'b1, 1'b0);
    end

    for (int i = 0; i < 16; i++) step("refill", 1'b1, W'($urandom), 1'b0, 1'b0);
    step("both_at_full", 1'b1, W'($urandom), 1'b1, 1'b0);
    chk("both_full_cnt", 32'(cnt0), 15);
    for (int i = 0; i < 15; i++) step("redrain", 1'b0, '0, 1'b1, 1'b0);
    step("both_at_empty", 1'b1, W'($urandom), 1'b1, 1'b0);
    chk("both_empty_cnt", 32'(cnt0), 1);
    chk("both_empty_udf", 32'(udf0), 1);

    for (int i = 0; i < 15; i++) step("fill_err", 1'b1, W'($urandom), 1'b0, 1'b0);
    step("clr_with_ovf", 1'b1, W'($urandom), 1'b0, 1'b1);
    chk("clr_set_wins", 32'(ovf0), 1);
    step("clr_alone", 1'b0, '0, 1'b0, 1'b1);
    chk("clr_clears", 32'(ovf0), 0);

    for (int i = 0; i < 16; i++) step("empty_fwft", 1'b0, '0, 1'b1, 1'b0);
    step("fwft_wr_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft_a5", 32'(rdata1), 32'hA5);
    step("fwft_wr_3c", 1'b1, 8'h3C, 1'b0, 1'b0);
    chk("fwft_hold", 32'(rdata1), 32'hA5);
    step("fwft_rd", 1'b0, '0, 1'b1, 1'b0);
    chk("fwft_adv", 32'(rdata1), 32'h3C);

    for (int i = 0; i < 300; i++)
      step("random", ($urandom_range(0, 99) < 55), W'($urandom),
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));

    for (int i = 0; i < 6; i++) step("pre_rst", 1'b1, W'($urandom), 1'b0, 1'b0);
    step("pre_rst_ovf", 1'b1, W'($urandom), 1'b0, 1'b0);
    w_en = 1'b1; wdata = W'($urandom);
    #3 rst_n = 1'b0;
    #1;
    q.delete(); m_ovf = 0; m_udf = 0; exp_rd0 = '0;
    chk("rst_mid_count", 32'(cnt0), 0);
    chk("rst_mid_empty", 32'(empty0), 1);
    chk("rst_mid_ovf", 32'(ovf0), 0);
    check_all("rst_mid");
    w_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("post_rst", 1'b1, W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Single-clock, parametrised FIFO: the same-clock successor to the team's dual-clock FIFO, for buffering between blocks that share one clock domain. Binary pointers with an extra wrap bit replace the Gray-coded cross-domain pointer exchange. The block adds what the dual-clock FIFO lacks:
- an exact fill count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- a selectable first-word-fall-through (FWFT) read mode.

## Interface
Parameters:
- MEMORY_WIDTH, 8, data word width in bits
- ADDRESS_SIZE, 4, log2 of depth; DEPTH = 2**ADDRESS_SIZE
- ALMOST_FULL_TH, 14, almost_full asserts when count >= this; legal range 1..DEPTH
- ALMOST_EMPTY_TH, 2, almost_empty asserts when count <= this; legal range 0..DEPTH-1
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- w_en  in  1  write request
- wdata  in  MEMORY_WIDTH  write data
- r_en  in  1  read request
- err_clr  in  1  clears overflow and underflow
- rdata  out  MEMORY_WIDTH  read data
- w_full  out  1  FIFO holds DEPTH words
- r_empty  out  1  FIFO holds 0 words
- almost_full  out  1  count >= ALMOST_FULL_TH
- almost_empty  out  1  count <= ALMOST_EMPTY_TH
- count  out  ADDRESS_SIZE+1  current number of stored words, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Pointers: w_ptr and r_ptr are ADDRESS_SIZE+1 bits wide.
  - The lower ADDRESS_SIZE bits address memory.
  - The MSB is the wrap bit, so pointers wrap naturally at 2*DEPTH.
- count = w_ptr - r_ptr, modulo 2**(ADDRESS_SIZE+1). count is held in a register and updated with +1, -1 or 0 each cycle.
- Flags are combinational decodes of the registered count:
  - w_full = (count == DEPTH)
  - r_empty = (count == 0)
  - almost_full and almost_empty per their thresholds.
- Accepted write: w_en & !w_full. The memory is written at w_ptr[ADDRESS_SIZE-1:0], then w_ptr increments.
- Accepted read: r_en & !r_empty. r_ptr increments.
- Full checks use the current-cycle count only: a write while full is rejected even if a read is accepted in the same cycle.
- Empty checks likewise: a read while empty is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- overflow sets on w_en & w_full; underflow sets on r_en & r_empty. If err_clr and a setting event occur in the same cycle, set wins.
- Rejected requests never modify pointers, count or memory.
- FWFT=0: rdata is registered and loads mem[r_ptr] on an accepted read. Otherwise rdata holds its value.
- FWFT=1: rdata = mem[r_ptr] combinationally and always shows the head word. rdata is undefined while r_empty=1.
- Reset values:
  - pointers 0, count 0
  - r_empty 1, w_full 0, almost_empty 1, almost_full 0
  - overflow 0, underflow 0
  - rdata 0 when FWFT=0; undefined when FWFT=1
  - Memory contents are not reset.
- Illegal threshold parameters stop elaboration with a $error.

## Timing
- Write-to-visible latency:
  - A word written at edge N raises count and deasserts r_empty after edge N.
  - FWFT=1: that word appears on rdata in the cycle after edge N.
  - FWFT=0: a read accepted at edge N+1 presents the word after edge N+1.
- Read latency with FWFT=0 is 1 cycle from the accepting edge.
- Flags and count change only on clk edges, or asynchronously on rst_n assertion.
- Reset asserted mid-operation:
  - Immediately clears all state listed above.
  - Words already stored are lost.
  - Deassertion is synchronised externally; the block assumes a clean release.

## Structure
- Shared package fifo_pkg holds:
  - FWFT_OFF and FWFT_ON mode constants
  - a clog2 helper function
  - the error-flag bit positions, reused by future FIFO variants
- One sub-module, fifo_mem_dp: MEMORY_WIDTH x DEPTH array with synchronous write and asynchronous read. It is shared with the dual-clock FIFO.
- Pointer, count, flag and error logic stay in fifo_sync_param.

## Test plan
- Reset, then 16 writes of 0x00..0x0F, defaults, FWFT=0:
  - count reaches 16; w_full=1 after the 16th edge; almost_full=1 from count 14.
  - A 17th write sets overflow and leaves count=16.
- Drain 16 reads from full:
  - FWFT=0: rdata = 0x00..0x0F in order, each 1 cycle after its read.
  - r_empty=1 after the last read; almost_empty=1 from count 2.
  - A further read sets underflow.
- Wrap-around: 40 interleaved write/read bursts of 5 words:
  - Data stays in order across the pointer MSB toggle.
  - count never exceeds 5.
- At count=16, assert w_en and r_en together: the read is accepted, the write is rejected, count becomes 15, overflow=1. Repeat at count=0 with both asserted: the write is accepted, the read is rejected, underflow=1.
- FWFT=1: write 0xA5 into an empty FIFO. rdata=0xA5 the cycle after the write edge with r_en low. An accepted read then advances rdata to the next word.
- Error flags and reset:
  - err_clr together with a new overflow event leaves overflow=1.
  - err_clr alone clears it.
  - Asserting rst_n=0 mid-burst immediately forces count=0, r_empty=1, overflow=0.
